// File: rtl/debug_jtag_scan_master.sv
// Host-side JTAG scan initiator. It walks the TAP through reset, then turns
// one-shot IR/DR scan commands into a TMS sequence and shifts TDI out while
// collecting TDO. TCK is derived from clk: a low phase of TCK_DIV clks, then
// a high phase of TCK_DIV clks. Every pin and handshake output is a flop.
module debug_jtag_scan_master #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 38,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam int PH_W  = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
    localparam int CYC_W = $clog2(MAX_LEN + 7);
    localparam int IDX_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

    localparam logic [PH_W-1:0]  PH_ZERO     = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_RISE     = PH_W'(TCK_DIV);
    localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(2 * TCK_DIV - 1);
    localparam logic [CYC_W-1:0] CYC_ZERO    = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
    localparam logic [CYC_W-1:0] INIT_CYCLES = CYC_W'(6);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r, state_n;
    logic [PH_W-1:0]      ph_r, ph_n;         // clk position inside the current TCK cycle
    logic [CYC_W-1:0]     cyc_r, cyc_n;       // TCK cycle index inside INIT or SCAN
    logic                 tck_r, tck_n;
    logic                 tms_r, tms_n;
    logic                 tdi_r, tdi_n;
    logic                 cmd_ready_r, cmd_ready_n;
    logic                 rsp_valid_r, rsp_valid_n;
    logic [MAX_LEN-1:0]   rsp_data_r, rsp_data_n;
    logic                 busy_r, busy_n;
    logic [MAX_LEN-1:0]   data_r, data_n;     // latched TDI bits
    logic [MAX_LEN-1:0]   cap_r, cap_n;       // TDO bits collected so far
    logic [CYC_W-1:0]     len_r, len_n;       // effective shift length N
    logic                 is_ir_r, is_ir_n;

    logic [CYC_W-1:0]     len_clamp_s;
    logic [CYC_W-1:0]     hdr_s;
    logic [CYC_W-1:0]     shift_end_s;
    logic [CYC_W-1:0]     total_s;
    logic                 in_shift_s;
    logic [IDX_W-1:0]     idx_s;
    logic                 scan_tms_s;
    logic                 walk_tms_s;
    logic [CYC_W-1:0]     walk_len_s;
    logic                 scanning_s;
    logic                 shift_tdi_s;

    // Map the requested length onto 1..MAX_LEN (zero means one bit).
    always_comb begin
        if (cmd_len == {LEN_W{1'b0}}) begin
            len_clamp_s = CYC_ONE;
        end else if (cmd_len > LEN_W'(MAX_LEN)) begin
            len_clamp_s = CYC_W'(MAX_LEN);
        end else begin
            len_clamp_s = CYC_W'(cmd_len);
        end
    end

    // Scan geometry: header walk to Shift, N shift cycles, then Update and Run-Test/Idle.
    always_comb begin
        hdr_s       = is_ir_r ? CYC_W'(4) : CYC_W'(3);
        shift_end_s = hdr_s + len_r;
        total_s     = shift_end_s + CYC_W'(2);
        in_shift_s  = (cyc_r >= hdr_s) && (cyc_r < shift_end_s);
        idx_s       = IDX_W'(cyc_r - hdr_s);
        scanning_s  = (state_r == ST_SCAN) && in_shift_s;
        shift_tdi_s = scanning_s ? data_r[idx_s] : 1'b0;
    end

    // TMS value for the current scan TCK cycle.
    always_comb begin
        if (cyc_r < hdr_s) begin
            scan_tms_s = (cyc_r == CYC_ZERO) || (is_ir_r && (cyc_r == CYC_ONE));
        end else if (in_shift_s) begin
            scan_tms_s = (cyc_r == (shift_end_s - CYC_ONE));
        end else if (cyc_r == shift_end_s) begin
            scan_tms_s = 1'b1;
        end else begin
            scan_tms_s = 1'b0;
        end
    end

    // Select the TMS pattern and cycle count of the walk in progress (INIT or SCAN).
    always_comb begin
        if (state_r == ST_INIT) begin
            walk_tms_s = (cyc_r < CYC_W'(5));
            walk_len_s = INIT_CYCLES;
        end else begin
            walk_tms_s = scan_tms_s;
            walk_len_s = total_s;
        end
    end

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_n     = state_r;
        ph_n        = ph_r;
        cyc_n       = cyc_r;
        tck_n       = tck_r;
        tms_n       = tms_r;
        tdi_n       = tdi_r;
        cmd_ready_n = cmd_ready_r;
        rsp_valid_n = rsp_valid_r;
        rsp_data_n  = rsp_data_r;
        busy_n      = busy_r;
        data_n      = data_r;
        cap_n       = cap_r;
        len_n       = len_r;
        is_ir_n     = is_ir_r;
        case (state_r)
            ST_INIT, ST_SCAN: begin
                if (ph_r == PH_ZERO) begin
                    // Start of a low phase: either the walk is over or the next TMS/TDI goes out.
                    tck_n = 1'b0;
                    if (cyc_r == walk_len_s) begin
                        ph_n  = PH_ZERO;
                        cyc_n = CYC_ZERO;
                        tms_n = 1'b0;
                        tdi_n = 1'b0;
                        if (state_r == ST_INIT) begin
                            state_n     = ST_IDLE;
                            cmd_ready_n = 1'b1;
                            busy_n      = 1'b0;
                        end else begin
                            state_n     = ST_DONE;
                            rsp_valid_n = 1'b1;
                            rsp_data_n  = cap_r;
                        end
                    end else begin
                        ph_n  = ph_r + PH_ONE;
                        tms_n = walk_tms_s;
                        tdi_n = shift_tdi_s;
                    end
                end else begin
                    if (ph_r == PH_RISE) begin
                        // TCK rises here; TDO is taken on this same clk.
                        tck_n = 1'b1;
                        if (scanning_s) begin
                            cap_n[idx_s] = tdo;
                        end else begin
                            cap_n = cap_r;
                        end
                    end else begin
                        tck_n = tck_r;
                    end
                    if (ph_r == PH_LAST) begin
                        ph_n  = PH_ZERO;
                        cyc_n = cyc_r + CYC_ONE;
                    end else begin
                        ph_n  = ph_r + PH_ONE;
                    end
                end
            end
            ST_IDLE: begin
                tck_n = 1'b0;
                tms_n = 1'b0;
                tdi_n = 1'b0;
                if (cmd_valid && cmd_ready_r) begin
                    state_n     = ST_SCAN;
                    cmd_ready_n = 1'b0;
                    busy_n      = 1'b1;
                    data_n      = cmd_data;
                    len_n       = len_clamp_s;
                    is_ir_n     = cmd_is_ir;
                    cap_n       = {MAX_LEN{1'b0}};
                    ph_n        = PH_ZERO;
                    cyc_n       = CYC_ZERO;
                end else begin
                    cmd_ready_n = 1'b1;
                    busy_n      = 1'b0;
                end
            end
            ST_DONE: begin
                state_n     = ST_IDLE;
                rsp_valid_n = 1'b0;
                cmd_ready_n = 1'b1;
                busy_n      = 1'b0;
            end
            default: begin
                state_n     = ST_INIT;
                ph_n        = PH_ZERO;
                cyc_n       = CYC_ZERO;
                tck_n       = 1'b0;
                tms_n       = 1'b1;
                tdi_n       = 1'b0;
                cmd_ready_n = 1'b0;
                rsp_valid_n = 1'b0;
                busy_n      = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset back into INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_INIT;
            ph_r        <= PH_ZERO;
            cyc_r       <= CYC_ZERO;
            tck_r       <= 1'b0;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {MAX_LEN{1'b0}};
            busy_r      <= 1'b1;
            data_r      <= {MAX_LEN{1'b0}};
            cap_r       <= {MAX_LEN{1'b0}};
            len_r       <= CYC_ZERO;
            is_ir_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            ph_r        <= ph_n;
            cyc_r       <= cyc_n;
            tck_r       <= tck_n;
            tms_r       <= tms_n;
            tdi_r       <= tdi_n;
            cmd_ready_r <= cmd_ready_n;
            rsp_valid_r <= rsp_valid_n;
            rsp_data_r  <= rsp_data_n;
            busy_r      <= busy_n;
            data_r      <= data_n;
            cap_r       <= cap_n;
            len_r       <= len_n;
            is_ir_r     <= is_ir_n;
        end
    end

    assign tck       = tck_r;
    assign tms       = tms_r;
    assign tdi       = tdi_r;
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_debug_jtag_scan_master.sv
// Bench for debug_jtag_scan_master: a behavioural TAP with a 2-bit IR and a
// 38-bit loopback DR sits on the JTAG pins; directed scans check responses,
// TCK counts, shift counts and the TAP/handshake sequencing.
module tb_debug_jtag_scan_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_ir = 1'b0;
    logic [5:0]  cmd_len = 6'd0;
    logic [37:0] cmd_data = 38'h0;
    logic        rsp_valid;
    logic [37:0] rsp_data;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    debug_jtag_scan_master #(.TCK_DIV(2), .MAX_LEN(38), .LEN_W(6)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_t;

    tap_t        tap_st = TLR;
    logic [1:0]  ir = 2'b01;
    logic [1:0]  ir_sh = 2'b00;
    logic [37:0] dr = 38'h15_1234_5678;
    logic [37:0] dr_sh = 38'h0;
    int          shift_cnt = 0;
    int          tck_cnt = 0;
    int          rsp_cnt = 0;
    int          acc_cnt = 0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PADR;
            PADR:    return m ? EX2DR : PADR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAIR;
            PAIR:    return m ? EX2IR : PAIR;
            EX2IR:   return m ? UPIR  : SHIR;
            UPIR:    return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    // TAP actions and state walk on rising TCK.
    always @(posedge tck) begin
        case (tap_st)
            TLR:   ir <= 2'b01;
            CAPDR: dr_sh <= dr;
            SHDR:  begin dr_sh <= {tdi, dr_sh[37:1]}; shift_cnt <= shift_cnt + 1; end
            UPDR:  dr <= dr_sh;
            CAPIR: ir_sh <= ir;
            SHIR:  begin ir_sh <= {tdi, ir_sh[1]}; shift_cnt <= shift_cnt + 1; end
            UPIR:  ir <= ir_sh;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
        tck_cnt <= tck_cnt + 1;
    end

    // TDO launches on falling TCK.
    always @(negedge tck) begin
        tdo <= (tap_st == SHDR) ? dr_sh[0] : ((tap_st == SHIR) ? ir_sh[0] : 1'b0);
    end

    // Handshake event counters.
    always @(posedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (cmd_ready) seen = 1'b1;
            else tick();
        end
        check_eq($sformatf("%s_ready_wait", tag), seen, 1);
    endtask

    // Expects reset just released; walks the 25 clks of INIT.
    task automatic init_check(input string tag);
        logic [5:0] seq = 6'b011111;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c <= 21 && ((c - 1) % 4) == 0)
                check_eq($sformatf("%s_tms%0d", tag, (c - 1) / 4), tms, seq[(c - 1) / 4]);
            if (c == 1) check_eq($sformatf("%s_tck_lo", tag), tck, 0);
            if (c == 3) check_eq($sformatf("%s_tck_hi", tag), tck, 1);
            if (c == 24) check_eq($sformatf("%s_ready24", tag), cmd_ready, 0);
        end
        check_eq($sformatf("%s_ready25", tag), cmd_ready, 1);
        check_eq($sformatf("%s_busy", tag), busy, 0);
        check_eq($sformatf("%s_tck_idle", tag), tck, 0);
        check_eq($sformatf("%s_tap_rti", tag), tap_st == RTI, 1);
    endtask

    task automatic run_scan(input string tag, input logic is_ir, input logic [5:0] len,
                            input logic [37:0] data, input logic [37:0] exp_rsp,
                            input int exp_tck, input int exp_shifts);
        int t0;
        int s0;
        bit got = 1'b0;
        wait_ready(tag);
        cmd_is_ir = is_ir;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        t0 = tck_cnt;
        s0 = shift_cnt;
        tick();
        cmd_valid = 1'b0;
        check_eq($sformatf("%s_ready_drop", tag), cmd_ready, 0);
        for (int i = 0; i < 2000 && !got; i++) begin
            tick();
            if (rsp_valid) got = 1'b1;
        end
        check_eq($sformatf("%s_rsp_seen", tag), got, 1);
        check_eq($sformatf("%s_rsp", tag), rsp_data, exp_rsp);
        check_eq($sformatf("%s_tck", tag), tck_cnt - t0, exp_tck);
        check_eq($sformatf("%s_shifts", tag), shift_cnt - s0, exp_shifts);
        check_eq($sformatf("%s_tap_rti", tag), tap_st == RTI, 1);
        tick();
        check_eq($sformatf("%s_pulse", tag), rsp_valid, 0);
        check_eq($sformatf("%s_ready_back", tag), cmd_ready, 1);
        check_eq($sformatf("%s_held", tag), rsp_data, exp_rsp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int r0;
        int a0;
        int nrsp;
        int idle;
        int viol;
        logic [37:0] r1;
        logic [37:0] r2;

        // Reset for three clks.
        repeat (3) tick();
        check_eq("rst_tck", tck, 0);
        check_eq("rst_tms", tms, 1);
        check_eq("rst_tdi", tdi, 0);
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_busy", busy, 1);
        reset = 1'b0;
        init_check("init");

        // IR scan: IR 01 -> 10, captures 01.
        run_scan("ir2", 1'b1, 6'd2, 38'h2, 38'h1, 8, 2);
        check_eq("ir2_ir", ir, 2'b10);

        // Full-length DR scan.
        run_scan("dr38", 1'b0, 6'd38, 38'h2A_5A5A_5A5A, 38'h15_1234_5678, 43, 38);
        check_eq("dr38_dr", dr, 38'h2A_5A5A_5A5A);

        // Length 0 shifts one bit; length 50 clamps to 38.
        run_scan("len0", 1'b0, 6'd0, 38'h3F_FFFF_FFFF, 38'h0, 6, 1);
        check_eq("len0_dr", dr, 38'h35_2D2D_2D2D);
        run_scan("len50", 1'b0, 6'd50, 38'h00_FFFF_0000, 38'h35_2D2D_2D2D, 43, 38);
        check_eq("len50_dr", dr, 38'h00_FFFF_0000);

        // Reset in the middle of a DR scan, at TCK cycle 10.
        wait_ready("rstmid");
        cmd_is_ir = 1'b0;
        cmd_len   = 6'd38;
        cmd_data  = 38'h0A_AAAA_5555;
        cmd_valid = 1'b1;
        t0 = tck_cnt;
        r0 = rsp_cnt;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 1000 && (tck_cnt - t0) < 10; i++) tick();
        check_eq("rstmid_reach", tck_cnt - t0, 10);
        reset = 1'b1;
        tick();
        check_eq("rstmid_tck", tck, 0);
        check_eq("rstmid_tms", tms, 1);
        check_eq("rstmid_busy", busy, 1);
        check_eq("rstmid_ready", cmd_ready, 0);
        reset = 1'b0;
        init_check("reinit");
        check_eq("rstmid_no_rsp", rsp_cnt - r0, 0);
        // Abandoned scan: 7 shifted bits plus one 0 on the way out, then Update.
        run_scan("post_a", 1'b0, 6'd38, 38'h12_3456_789A, 38'h15_40FF_FF00, 43, 38);
        run_scan("post_b", 1'b0, 6'd38, 38'h0, 38'h12_3456_789A, 43, 38);

        // cmd_valid held high across two commands.
        wait_ready("hold");
        a0 = acc_cnt;
        r0 = rsp_cnt;
        nrsp = 0;
        idle = 0;
        viol = 0;
        r1 = 38'h0;
        r2 = 38'h0;
        cmd_is_ir = 1'b0;
        cmd_len   = 6'd38;
        cmd_data  = 38'h3C_0F0F_F0F0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 1000 && nrsp < 2; i++) begin
            tick();
            if (acc_cnt - a0 >= 1) cmd_data = 38'h01_8000_0001;
            if (acc_cnt - a0 >= 2) cmd_valid = 1'b0;
            if (rsp_valid) begin
                if (nrsp == 0) r1 = rsp_data;
                else r2 = rsp_data;
                nrsp++;
            end else if ((acc_cnt - a0) > nrsp && cmd_ready) begin
                viol++;
            end
            if (nrsp == 1 && !busy) idle++;
        end
        cmd_valid = 1'b0;
        check_eq("hold_nrsp", nrsp, 2);
        check_eq("hold_rsp1", r1, 38'h0);
        check_eq("hold_rsp2", r2, 38'h3C_0F0F_F0F0);
        check_eq("hold_ready_low", viol, 0);
        check_eq("hold_idle_gap", idle >= 1, 1);
        repeat (8) tick();
        check_eq("hold_acc", acc_cnt - a0, 2);
        check_eq("hold_pulses", rsp_cnt - r0, 2);
        check_eq("hold_data_kept", rsp_data, 38'h3C_0F0F_F0F0);
        check_eq("hold_dr", dr, 38'h01_8000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
